led_frame_tx: RTL
=================

// Module: led_frame_tx
// PURPOSE
//  Downstream consumer of the SPI-to-SPRAM loader. On start, reads NUM_WORDS 16-bit words from SPRAM.
//  Streams each word MSB-first onto a single-wire addressable-LED data line (WS2812-style pulse-width code).
//  Ends each frame with a low latch period. Gives the MCU-loaded light string a physical output.
// PARAMETERS
//  NUM_WORDS  150    words per frame (1..16384)
//  BASE_ADDR  0      SPRAM word address of first word
//  T0H_CYC    19     high cycles for a 0 bit (0.4 us @ 48 MHz)
//  T1H_CYC    38     high cycles for a 1 bit (0.8 us)
//  BIT_CYC    60     total cycles per bit (1.25 us); must exceed T1H_CYC
//  LATCH_CYC  14400  low cycles after last bit (300 us)
// PORTS
//  clk      in   1   FPGA system clock; all logic on posedge
//  reset    in   1   asynchronous, active-high reset
//  start    in   1   1-cycle pulse: begin frame
//  rd_en    out  1   SPRAM read strobe; rd_data is valid exactly 1 clk later
//  rd_addr  out  14  SPRAM word address
//  rd_data  in   16  SPRAM read data
//  dout     out  1   LED data line
//  busy     out  1   high from accepted start until done
//  done     out  1   1-cycle pulse at end of latch period
// BEHAVIOUR
//  Reset (async): state=IDLE, dout=0, busy=0, done=0, rd_en=0, rd_addr=BASE_ADDR, all counters 0.
//  FSM: IDLE -> FETCH -> WAIT -> LOAD -> HIGH <-> LOW -> (FETCH | LATCH) -> IDLE.
//  IDLE: dout=0. start=1 -> FETCH, busy=1, word_cnt=0, rd_addr=BASE_ADDR.
//  FETCH: rd_en=1 for this cycle only.
//  WAIT: SPRAM latency cycle.
//  LOAD: shreg <= rd_data, bit_cnt=15, cyc_cnt=0.
//  HIGH: dout=1; stays for T1H_CYC cycles if shreg[15] else T0H_CYC; then -> LOW.
//  LOW: dout=0 until cyc_cnt reaches BIT_CYC-1 (bit total = BIT_CYC cycles).
//  LOW, bit_cnt>0: shreg<<=1, bit_cnt--, -> HIGH.
//  LOW, bit_cnt==0, word_cnt<NUM_WORDS-1: word_cnt++, rd_addr++, -> FETCH.
//  LOW, bit_cnt==0, last word: -> LATCH.
//  Inter-word gap: the last bit's low time is extended by exactly 3 cycles (FETCH, WAIT, LOAD).
//  The same 3 cycles precede the first bit.
//  LATCH: dout=0 for LATCH_CYC cycles; final cycle asserts done=1, busy drops with it, -> IDLE.
//  rd_addr is 14 bits and wraps mod 2^14 if BASE_ADDR+NUM_WORDS exceeds 16384; no error flag.
//  start while busy (including during LATCH): ignored, no restart, no queueing.
//  start in same cycle as done: ignored; MCU re-issues after done.
//  Reset mid-frame: dout forced low immediately; partial frame is abandoned.
//  The LED chain sees an extended low and treats it as a latch.
//  cyc_cnt width = $clog2(max(BIT_CYC,LATCH_CYC)); counters never overflow within a state.
//  rd_en never asserted outside FETCH. dout is registered, glitch-free.
// STRUCTURE
//  Shared package led_pkg:
//   - txstate_t enum {IDLE,FETCH,WAIT,LOAD,HIGH,LOW,LATCH}
//   - default timing localparams (T0H/T1H/BIT/LATCH @ 48 MHz)
//   - SPRAM address width (14)
//  Sub-module led_bit_timer: cycle counter plus high/low compare for one bit.
//   - inputs: bit value, go
//   - outputs: dout_hi, bit_end
//  Top module holds FSM, shift register, word/address counters.
// TESTING
//  1. Reset asserted mid-HIGH -> dout=0 same cycle; busy=0, rd_en=0; no done pulse.
//  2. NUM_WORDS=1, rd_data=16'hA5F0, start -> rd_en at addr 0 once.
//     16 bits observed: high widths 38,19,38,19,19,38,19,38,38,38,38,38,19,19,19,19.
//     Each bit period is 60 cycles.
//  3. NUM_WORDS=2, BASE_ADDR=14'h3FFF -> reads at 3FFF then 0000.
//     Low time between word0 bit0 and word1 bit15 = (60-19)+3 cycles.
//  4. Frame end -> dout low for 14400 cycles.
//     done pulses once at the last latch cycle, busy falls the same cycle.
//  5. start re-pulsed at bit 5 and during LATCH -> frame unchanged, exactly one done.
//  6. rd_data=16'h0000 then 16'hFFFF -> all highs 19, then all highs 38; no extra rd_en.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and default timing for the addressable-LED frame transmitter.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } txstate_t;

  // SPRAM word address width
  localparam int unsigned ADDR_W = 14;

  // Default pulse timing at 48 MHz
  localparam int unsigned DEF_T0H_CYC   = 19;
  localparam int unsigned DEF_T1H_CYC   = 38;
  localparam int unsigned DEF_BIT_CYC   = 60;
  localparam int unsigned DEF_LATCH_CYC = 14400;

  // Width of a counter that must hold values up to max(a,b)-1
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Per-bit cycle counter: times the high phase and the full bit period.
module led_bit_timer
  import led_pkg::*;
#(
  parameter int unsigned T0H_CYC = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC = DEF_BIT_CYC,
  parameter int unsigned CW      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic go,       // high while a bit is being transmitted
  input  logic bit_val,  // value of the bit being transmitted
  output logic dout_hi,  // high phase continues into the next cycle
  output logic bit_end   // this is the final cycle of the bit period
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_last;

  // Last counter value of the high phase for the current bit
  always_comb begin
    hi_last = bit_val ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
    dout_hi = go && (cnt_q < hi_last);
    bit_end = go && (cnt_q == CW'(BIT_CYC - 1));
    cnt_d   = (!go || bit_end) ? '0 : cnt_q + CW'(1);
  end

  // Counter register, restarts at every bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_frame_tx.sv
// Reads a frame of 16-bit words from SPRAM and serialises them MSB-first
// onto a single-wire pulse-width coded LED data line, followed by a latch gap.
module led_frame_tx
  import led_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 150,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned T0H_CYC   = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC   = DEF_T1H_CYC,
  parameter int unsigned BIT_CYC   = DEF_BIT_CYC,
  parameter int unsigned LATCH_CYC = DEF_LATCH_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = cnt_width(BIT_CYC, LATCH_CYC);
  localparam int unsigned WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  txstate_t          state_q, state_d;
  logic [15:0]       shreg_q, shreg_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]     latch_cnt_q, latch_cnt_d;
  logic              dout_q, dout_d;

  logic bit_go, dout_hi, bit_end;
  logic last_word, latch_last;

  assign bit_go     = (state_q == HIGH) || (state_q == LOW);
  assign last_word  = (word_cnt_q == WW'(NUM_WORDS - 1));
  assign latch_last = (latch_cnt_q == CW'(LATCH_CYC - 1));

  led_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC),
    .CW      (CW)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (reset),
    .go      (bit_go),
    .bit_val (shreg_q[15]),
    .dout_hi (dout_hi),
    .bit_end (bit_end)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: state_d = WAIT;
      WAIT:  state_d = LOAD;
      LOAD:  state_d = HIGH;
      HIGH:  if (!dout_hi) state_d = LOW;
      LOW: begin
        if (bit_end) begin
          if (bit_cnt_q != 4'd0) state_d = HIGH;
          else if (!last_word)   state_d = FETCH;
          else                   state_d = LATCH;
        end
      end
      LATCH: if (latch_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; busy drops in the same cycle done pulses
  always_comb begin
    rd_en = (state_q == FETCH);
    done  = (state_q == LATCH) && latch_last;
    busy  = (state_q != IDLE) && !done;
  end

  // Datapath next-state: shift register, bit/word/address and latch counters
  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    rd_addr_d   = rd_addr_q;
    latch_cnt_d = latch_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          word_cnt_d = '0;
          rd_addr_d  = ADDR_W'(BASE_ADDR);
        end
      end
      LOAD: begin
        shreg_d   = rd_data;
        bit_cnt_d = 4'd15;
      end
      LOW: begin
        if (bit_end) begin
          if (bit_cnt_q != 4'd0) begin
            shreg_d   = {shreg_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
          end else if (!last_word) begin
            word_cnt_d = word_cnt_q + WW'(1);
            rd_addr_d  = rd_addr_q + ADDR_W'(1);
          end else begin
            latch_cnt_d = '0;
          end
        end
      end
      LATCH: latch_cnt_d = latch_last ? '0 : latch_cnt_q + CW'(1);
      default: ;
    endcase
  end

  // dout is registered from the next state so it tracks HIGH exactly, glitch-free
  assign dout_d = (state_d == HIGH);

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      rd_addr_q   <= ADDR_W'(BASE_ADDR);
      latch_cnt_q <= '0;
      dout_q      <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      rd_addr_q   <= rd_addr_d;
      latch_cnt_q <= latch_cnt_d;
      dout_q      <= dout_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign dout    = dout_q;

endmodule
